// File: rtl/axis2vga_ctrl_s_axi.sv
// AXI4-Lite control/status register bank for the AXIS2VGA video output path.
//
// Register map (word index = addr[4:2]):
//   0..3  REG0..REG3  RW, byte-strobed, driven out on ctrl_regs
//   4     STATUS      RO, status_in captured at the AR handshake edge
//   5     FRAME_CNT   counts vsync_in rising edges; any write clears it
//   6,7   reserved    read 0, writes dropped
//
// Ports:
//   s00_axi_aclk / s00_axi_areset  clock, synchronous active-high reset
//   s00_axi_aw* / w* / b*          write address, data and response channels
//   s00_axi_ar* / r*               read address and data channels
//   ctrl_regs                      {REG3, REG2, REG1, REG0} to the datapath
//   status_in                      live status word from the datapath
//   vsync_in                       vertical sync, active-high, clock-synchronous
module axis2vga_ctrl_s_axi #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [127:0]                    ctrl_regs,
  input  logic [31:0]                     status_in,
  input  logic                            vsync_in
);

  typedef enum logic [1:0] {WIdle, WGotAw, WGotW, WResp} w_state_t;
  typedef enum logic {RIdle, RData} r_state_t;

  w_state_t    w_state;
  r_state_t    r_state;
  logic [2:0]  aw_idx_lat;
  logic [31:0] wdata_lat;
  logic [3:0]  wstrb_lat;
  logic [31:0] regs [4];
  logic [31:0] frame_cnt;
  logic        vsync_prev;

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_commit;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] rd_word;

  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign aw_hs = s00_axi_awvalid & s00_axi_awready;
  assign w_hs  = s00_axi_wvalid & s00_axi_wready;
  assign ar_hs = s00_axi_arvalid & s00_axi_arready;

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;
  assign ctrl_regs     = {regs[3], regs[2], regs[1], regs[0]};

  // The commit takes whichever half arrives now and the latched copy of the other half.
  always_comb begin
    wr_commit = 1'b0;
    wr_idx    = s00_axi_awaddr[4:2];
    wr_data   = s00_axi_wdata;
    wr_strb   = s00_axi_wstrb;
    unique case (w_state)
      WIdle:  wr_commit = aw_hs & w_hs;
      WGotAw: begin
        wr_commit = w_hs;
        wr_idx    = aw_idx_lat;
      end
      WGotW: begin
        wr_commit = aw_hs;
        wr_data   = wdata_lat;
        wr_strb   = wstrb_lat;
      end
      WResp:  wr_commit = 1'b0;
    endcase
  end

  always_comb begin
    rd_word = 32'h0;
    case (s00_axi_araddr[4:2])
      3'd0:    rd_word = regs[0];
      3'd1:    rd_word = regs[1];
      3'd2:    rd_word = regs[2];
      3'd3:    rd_word = regs[3];
      3'd4:    rd_word = status_in;
      3'd5:    rd_word = frame_cnt;
      default: rd_word = 32'h0;
    endcase
  end

  // Write FSM; ready/valid outputs are registered.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      w_state         <= WIdle;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      aw_idx_lat      <= 3'd0;
      wdata_lat       <= 32'h0;
      wstrb_lat       <= 4'h0;
    end else begin
      unique case (w_state)
        WIdle: begin
          s00_axi_awready <= 1'b1;
          s00_axi_wready  <= 1'b1;
          if (aw_hs && w_hs) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b1;
            w_state         <= WResp;
          end else if (aw_hs) begin
            aw_idx_lat      <= s00_axi_awaddr[4:2];
            s00_axi_awready <= 1'b0;
            w_state         <= WGotAw;
          end else if (w_hs) begin
            wdata_lat      <= s00_axi_wdata;
            wstrb_lat      <= s00_axi_wstrb;
            s00_axi_wready <= 1'b0;
            w_state        <= WGotW;
          end
        end
        WGotAw: if (w_hs) begin
          s00_axi_wready <= 1'b0;
          s00_axi_bvalid <= 1'b1;
          w_state        <= WResp;
        end
        WGotW: if (aw_hs) begin
          s00_axi_awready <= 1'b0;
          s00_axi_bvalid  <= 1'b1;
          w_state         <= WResp;
        end
        WResp: if (s00_axi_bready) begin
          s00_axi_bvalid  <= 1'b0;
          s00_axi_awready <= 1'b1;
          s00_axi_wready  <= 1'b1;
          w_state         <= WIdle;
        end
      endcase
    end
  end

  // Read FSM; rdata is captured once per AR and held until R completes.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_state         <= RIdle;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      unique case (r_state)
        RIdle: begin
          s00_axi_arready <= 1'b1;
          if (ar_hs) begin
            s00_axi_rdata   <= rd_word;
            s00_axi_rvalid  <= 1'b1;
            s00_axi_arready <= 1'b0;
            r_state         <= RData;
          end
        end
        RData: if (s00_axi_rready) begin
          s00_axi_rvalid  <= 1'b0;
          s00_axi_arready <= 1'b1;
          r_state         <= RIdle;
        end
      endcase
    end
  end

  // Register bank and frame counter; a clear from the bus beats a coincident vsync edge.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < 4; i++) regs[i] <= 32'h0;
      frame_cnt  <= 32'h0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      if (wr_commit && wr_idx == 3'd5) begin
        frame_cnt <= 32'h0;
      end else if (vsync_in && !vsync_prev) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
      if (wr_commit && !wr_idx[2]) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_strb[k]) regs[wr_idx[1:0]][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axis2vga_ctrl_s_axi.sv
// Directed plus randomized bench for axis2vga_ctrl_s_axi against a register-map model.
module tb_axis2vga_ctrl_s_axi;

  logic         clk = 1'b0;
  logic         areset;
  logic [4:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata, status_in;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] ctrl_regs;
  logic         vsync_in;

  int checks = 0;
  int failures = 0;

  logic [31:0] reg_m [4];
  logic [31:0] frame_m;

  always #5 clk = ~clk;

  axis2vga_ctrl_s_axi dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .ctrl_regs       (ctrl_regs),
    .status_in       (status_in),
    .vsync_in        (vsync_in)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_ctrl();
    return {reg_m[3], reg_m[2], reg_m[1], reg_m[0]};
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    if (idx < 4) return reg_m[idx];
    if (idx == 4) return status_in;
    if (idx == 5) return frame_m;
    return 32'h0;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx < 4) begin
      for (int k = 0; k < 4; k++) if (s[k]) reg_m[idx][8*k +: 8] = d[8*k +: 8];
    end else if (idx == 5) begin
      frame_m = 32'h0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) reg_m[i] = 32'h0;
    frame_m = 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge. mode 0: AW+W together, 1: AW 3 cycles ahead, 2: W 3 cycles ahead.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int mode, input int bdelay);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = (mode != 2);
    wvalid  = (mode != 1);
    while (!(aw_done && w_done) && cyc < 50) begin
      if (cyc == 3) begin
        awvalid = !aw_done;
        wvalid  = !w_done;
      end
      if (w_done && !aw_done) chk("w_hold_wready", wready, 0);
      if (aw_done && !w_done) chk("aw_hold_awready", awready, 0);
      if (aw_done ^ w_done)   chk("hold_no_bvalid", bvalid, 0);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      tick();
      if (aw_fire) begin aw_done = 1; awvalid = 0; end
      if (w_fire)  begin w_done = 1;  wvalid = 0;  end
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      chk("write_timeout", 0, 1);
      awvalid = 0; wvalid = 0;
      return;
    end
    model_write(int'(a[4:2]), d, s);
    chk("bvalid_at_commit", bvalid, 1);
    chk("bresp_okay", bresp, 0);
    chk("ctrl_regs_after_write", ctrl_regs, model_ctrl());
    repeat (bdelay) begin
      tick();
      chk("bvalid_held", bvalid, 1);
      chk("no_aw_during_b", awready, 0);
    end
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_cleared", bvalid, 0);
    chk("awready_after_b", awready, 1);
    chk("wready_after_b", wready, 1);
  endtask

  // Called at a negedge; status_in is scrambled while R is stalled to prove rdata is held.
  task automatic axi_read(input logic [4:0] a, input int rdelay);
    logic [31:0] exp = 32'h0;
    bit fired = 0;
    int cyc = 0;
    araddr = a; arvalid = 1;
    while (!fired && cyc < 50) begin
      if (arready) begin
        fired = 1;
        exp = model_read(int'(a[4:2]));
      end
      tick();
      cyc++;
    end
    arvalid = 0;
    if (!fired) begin
      chk("read_timeout", 0, 1);
      return;
    end
    chk("rvalid_after_ar", rvalid, 1);
    chk("rresp_okay", rresp, 0);
    chk("rdata", rdata, exp);
    repeat (rdelay) begin
      status_in = $urandom;
      tick();
      chk("rvalid_held", rvalid, 1);
      chk("rdata_held", rdata, exp);
      chk("no_ar_during_r", arready, 0);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("rvalid_cleared", rvalid, 0);
    chk("arready_after_r", arready, 1);
  endtask

  task automatic vsync_pulse();
    vsync_in = 1;
    tick();
    frame_m = frame_m + 32'd1;
    vsync_in = 0;
    tick();
  endtask

  initial begin
    areset = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = 0; wstrb = 0; status_in = 32'hCAFE_0001; vsync_in = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ctrl_regs", ctrl_regs, 0);
    areset = 0;
    tick();
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);

    // Basic write and read back
    for (int i = 0; i < 4; i++) axi_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(5'(4 * i), 0);
    chk("ctrl_regs_basic", ctrl_regs, 128'h00000004_00000003_00000002_00000001);

    // W ahead of AW, then AW ahead of W
    axi_write(5'h04, 32'hDEAD_BEEF, 4'hF, 2, 0);
    chk("reg1_w_first", ctrl_regs[63:32], 32'hDEAD_BEEF);
    axi_write(5'h0C, 32'h0BAD_F00D, 4'hF, 1, 1);

    // Byte strobes
    axi_write(5'h08, 32'h1122_3344, 4'hF, 0, 0);
    axi_write(5'h0A, 32'hAABB_CCDD, 4'b0101, 0, 0);
    chk("reg2_strobe", ctrl_regs[95:64], 32'h11BB_33DD);
    axi_write(5'h08, 32'hFFFF_FFFF, 4'b0000, 0, 0);
    axi_read(5'h08, 0);

    // Backpressure on B and R
    axi_write(5'h00, 32'h5A5A_A5A5, 4'hF, 0, 5);
    status_in = 32'h1234_5678;
    axi_read(5'h10, 5);
    axi_read(5'h18, 1);

    // Frame counter: count, coincident clear, wrap
    axi_write(5'h14, 32'h0, 4'h0, 0, 0);
    repeat (3) vsync_pulse();
    axi_read(5'h14, 0);
    chk("frame_cnt_three", frame_m, 3);
    fork
      vsync_in = 1;
      axi_write(5'h14, 32'h0, 4'hF, 0, 0);
    join
    vsync_in = 0;
    tick();
    axi_read(5'h14, 0);
    force dut.frame_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.frame_cnt;
    frame_m = 32'hFFFF_FFFF;
    axi_read(5'h14, 0);
    vsync_pulse();
    axi_read(5'h14, 0);

    // Read and write to the same register on the same edge
    fork
      axi_write(5'h04, 32'h7777_8888, 4'hF, 0, 0);
      axi_read(5'h04, 0);
    join
    axi_read(5'h04, 0);

    // Reset between AW and W
    vsync_pulse();
    awaddr = 5'h00; awvalid = 1; wdata = 32'h9999_9999; wstrb = 4'hF;
    tick();
    awvalid = 0;
    chk("midwr_awready_low", awready, 0);
    areset = 1;
    tick();
    chk("midwr_rst_awready", awready, 0);
    chk("midwr_rst_ctrl", ctrl_regs, 0);
    areset = 0;
    model_reset();
    repeat (3) begin
      tick();
      chk("midwr_no_bvalid", bvalid, 0);
    end
    chk("midwr_wready", wready, 1);
    axi_write(5'h00, 32'h0000_ABCD, 4'hF, 0, 0);
    axi_read(5'h14, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int op;
      logic [4:0] a;
      op = $urandom_range(0, 9);
      a = 5'($urandom_range(0, 31));
      if (op < 5) begin
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      end else if (op < 9) begin
        status_in = $urandom;
        axi_read(a, $urandom_range(0, 3));
      end else begin
        vsync_pulse();
      end
    end
    for (int i = 0; i < 6; i++) axi_read(5'(4 * i), 0);
    chk("ctrl_regs_final", ctrl_regs, model_ctrl());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
